// File: rtl/narrow_to_wide.sv
// Packs narrow beats into wide lines of OUT_DATA_ELS elements. The first beat of a
// line lands in the top element, and a beat with last closes the line early, zero-filling the rest.
module narrow_to_wide #(
    parameter int IN_DATA_W    = -1,
    parameter int IN_KEEP_W    = IN_DATA_W / 8,
    parameter int OUT_DATA_ELS = -1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   src_n_to_w_val,
    input  logic [IN_DATA_W-1:0]                   src_n_to_w_data,
    input  logic [IN_KEEP_W-1:0]                   src_n_to_w_keep,
    input  logic                                   src_n_to_w_last,
    output logic                                   n_to_w_src_rdy,
    output logic                                   n_to_w_dst_val,
    output logic [OUT_DATA_ELS-1:0][IN_DATA_W-1:0] n_to_w_dst_data,
    output logic [OUT_DATA_ELS-1:0][IN_KEEP_W-1:0] n_to_w_dst_keep,
    output logic                                   n_to_w_dst_last,
    input  logic                                   dst_n_to_w_rdy
);

    localparam int IDX_W = $clog2(OUT_DATA_ELS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(OUT_DATA_ELS - 1);

    logic [IDX_W-1:0]                   idx_reg, idx_next;
    logic [OUT_DATA_ELS-1:0][IN_DATA_W-1:0] acc_data_reg, acc_data_next, line_data;
    logic [OUT_DATA_ELS-1:0][IN_KEEP_W-1:0] acc_keep_reg, acc_keep_next, line_keep;
    logic                                   out_val_reg, out_last_reg;
    logic [OUT_DATA_ELS-1:0][IN_DATA_W-1:0] out_data_reg;
    logic [OUT_DATA_ELS-1:0][IN_KEEP_W-1:0] out_keep_reg;
    logic                                   acc_fire, line_done;

    assign n_to_w_src_rdy = rst_n & (~out_val_reg | dst_n_to_w_rdy);
    assign acc_fire       = src_n_to_w_val & n_to_w_src_rdy;
    assign line_done      = acc_fire & ((idx_reg == '0) | src_n_to_w_last);

    // Per element: the line to emit (beat merged in, lower elements zeroed) and the next accumulator.
    for (genvar gi = 0; gi < OUT_DATA_ELS; gi++) begin : g_el
        localparam logic [IDX_W-1:0] EL = IDX_W'(gi);
        assign line_data[gi] = (EL == idx_reg) ? src_n_to_w_data :
                               (EL <  idx_reg) ? '0 : acc_data_reg[gi];
        assign line_keep[gi] = (EL == idx_reg) ? src_n_to_w_keep :
                               (EL <  idx_reg) ? '0 : acc_keep_reg[gi];
        assign acc_data_next[gi] = line_done ? '0 :
                                   (acc_fire && EL == idx_reg) ? src_n_to_w_data : acc_data_reg[gi];
        assign acc_keep_next[gi] = line_done ? '0 :
                                   (acc_fire && EL == idx_reg) ? src_n_to_w_keep : acc_keep_reg[gi];
    end

    always_comb begin
        idx_next = idx_reg;
        if (line_done)
            idx_next = IDX_TOP;
        else if (acc_fire)
            idx_next = idx_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg      <= IDX_TOP;
            acc_data_reg <= '0;
            acc_keep_reg <= '0;
        end else begin
            idx_reg      <= idx_next;
            acc_data_reg <= acc_data_next;
            acc_keep_reg <= acc_keep_next;
        end
    end

    // A completing beat reloads the output even while the previous line drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val_reg  <= 1'b0;
            out_last_reg <= 1'b0;
            out_data_reg <= '0;
            out_keep_reg <= '0;
        end else if (line_done) begin
            out_val_reg  <= 1'b1;
            out_last_reg <= src_n_to_w_last;
            out_data_reg <= line_data;
            out_keep_reg <= line_keep;
        end else if (dst_n_to_w_rdy) begin
            out_val_reg  <= 1'b0;
        end
    end

    assign n_to_w_dst_val  = out_val_reg;
    assign n_to_w_dst_data = out_data_reg;
    assign n_to_w_dst_keep = out_keep_reg;
    assign n_to_w_dst_last = out_last_reg;

endmodule

// File: tb/tb_narrow_to_wide.sv
// Randomized and directed bench for narrow_to_wide; a queue-based line model
// predicts every output line, ready and valid, checked once per cycle.
module tb_narrow_to_wide;
    localparam int DW  = 64;
    localparam int KW  = 8;
    localparam int ELS = 4;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     src_val = 1'b0;
    logic [DW-1:0]            src_data = '0;
    logic [KW-1:0]            src_keep = '0;
    logic                     src_last = 1'b0;
    logic                     src_rdy;
    logic                     dst_val;
    logic [ELS-1:0][DW-1:0]   dst_data;
    logic [ELS-1:0][KW-1:0]   dst_keep;
    logic                     dst_last;
    logic                     dst_rdy = 1'b1;

    always #5 clk = ~clk;

    narrow_to_wide #(.IN_DATA_W(DW), .IN_KEEP_W(KW), .OUT_DATA_ELS(ELS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_n_to_w_val  (src_val),
        .src_n_to_w_data (src_data),
        .src_n_to_w_keep (src_keep),
        .src_n_to_w_last (src_last),
        .n_to_w_src_rdy  (src_rdy),
        .n_to_w_dst_val  (dst_val),
        .n_to_w_dst_data (dst_data),
        .n_to_w_dst_keep (dst_keep),
        .n_to_w_dst_last (dst_last),
        .dst_n_to_w_rdy  (dst_rdy)
    );

    typedef struct packed {
        logic [ELS*DW-1:0] d;
        logic [ELS*KW-1:0] k;
        logic              l;
    } line_t;

    line_t         exp_q[$];
    logic [DW-1:0] beat_d_q[$];
    logic [KW-1:0] beat_k_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        beat_d_q.delete();
        beat_k_q.delete();
    endtask

    // Model: at most one line pending; beats accepted whenever nothing is pending or it drains.
    task automatic monitor();
        bit    pend;
        bit    rdy_exp;
        line_t ln;
        pend    = (exp_q.size() != 0);
        rdy_exp = !pend || dst_rdy;
        check_eq("src_rdy", 256'(src_rdy), 256'(rdy_exp));
        check_eq("dst_val", 256'(dst_val), 256'(pend));
        if (pend) begin
            check_eq("dst_data", dst_data, exp_q[0].d);
            check_eq("dst_keep", 256'(dst_keep), 256'(exp_q[0].k));
            check_eq("dst_last", 256'(dst_last), 256'(exp_q[0].l));
            $display("cycle %0d line data=%h keep=%h last=%0b rdy=%0b",
                     cyc, dst_data, dst_keep, dst_last, dst_rdy);
            if (dst_rdy) void'(exp_q.pop_front());
        end
        if (src_val && rdy_exp) begin
            beat_d_q.push_back(src_data);
            beat_k_q.push_back(src_keep);
            if (beat_d_q.size() == ELS || src_last) begin
                ln = '0;
                for (int i = 0; i < beat_d_q.size(); i++) begin
                    ln.d[(ELS-1-i)*DW +: DW] = beat_d_q[i];
                    ln.k[(ELS-1-i)*KW +: KW] = beat_k_q[i];
                end
                ln.l = src_last;
                exp_q.push_back(ln);
                beat_d_q.delete();
                beat_k_q.delete();
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                         input bit l, input bit dr);
        @(posedge clk);
        #1;
        src_val = v; src_data = d; src_keep = k; src_last = l; dst_rdy = dr;
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_val"},  256'(dst_val), 256'(0));
        check_eq({tag, "_data"}, dst_data, 256'(0));
        check_eq({tag, "_keep"}, 256'(dst_keep), 256'(0));
        check_eq({tag, "_last"}, 256'(dst_last), 256'(0));
        check_eq({tag, "_rdy"},  256'(src_rdy), 256'(0));
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        // Reset held from time zero.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rdy_after_rst", 256'(src_rdy), 256'(1));

        // Full line A,B,C,D.
        cycle(1, 64'hAAAA_0000_0000_000A, 8'hFF, 0, 1);
        cycle(1, 64'hBBBB_0000_0000_000B, 8'hFF, 0, 1);
        cycle(1, 64'hCCCC_0000_0000_000C, 8'hFF, 0, 1);
        cycle(1, 64'hDDDD_0000_0000_000D, 8'hFF, 1, 1);
        cycle(0, '0, '0, 0, 1);

        // Short line: A full, B half-keep with last.
        cycle(1, 64'h1111_2222_3333_4444, 8'hFF, 0, 1);
        cycle(1, 64'h5555_6666_7777_8888, 8'h0F, 1, 1);
        cycle(0, '0, '0, 0, 1);

        // Streaming 12 beats.
        for (int i = 0; i < 12; i++) cycle(1, rnd64(), 8'(i), i == 11, 1);
        cycle(0, '0, '0, 0, 1);

        // Backpressure: line held, then drain coinciding with a completing beat.
        for (int i = 0; i < 4; i++) cycle(1, rnd64(), 8'hFF, 0, 1);
        for (int i = 0; i < 3; i++) cycle(1, rnd64(), 8'hF0, 0, 0);
        cycle(1, 64'hFEED_0000_0000_0001, 8'h3C, 1, 1);
        check_eq("bp_reload_pending", 256'(exp_q.size()), 256'(1));
        cycle(0, '0, '0, 0, 0);
        cycle(0, '0, '0, 0, 1);

        // Reset mid-line after two beats.
        cycle(1, rnd64(), 8'hFF, 0, 1);
        cycle(1, rnd64(), 8'hFF, 0, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0; src_val = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1, rnd64(), 8'(8'hA0 + i), i == 3, 1);
        cycle(0, '0, '0, 0, 1);

        // Randomized traffic with random backpressure and short lines.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, rnd64(), 8'($urandom()),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, '0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/narrow_to_wide.md
# narrow_to_wide

Packs a stream of narrow beats into wide lines of `OUT_DATA_ELS` elements, the inverse of the wide-to-narrow data converter. It sits on the receive side of the datapath, where narrow MAC/PHY-side or serialized streams must be re-assembled into full-width lines for the wide buffers. The first narrow beat of each line lands in the most-significant element. A narrow beat with `last` set closes a short line whose unfilled elements are zeroed. Input ready is helpful and output valid is registered.

## Interface
- `IN_DATA_W`, default -1 (must be overridden): narrow beat data width in bits.
- `IN_KEEP_W`, default `IN_DATA_W/8`: narrow beat keep width.
- `OUT_DATA_ELS`, default -1 (must be overridden, ≥2, power of two): narrow elements per wide line.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `src_n_to_w_val` in 1: narrow beat valid.
- `src_n_to_w_data` in `IN_DATA_W`: narrow beat data.
- `src_n_to_w_keep` in `IN_KEEP_W`: narrow beat byte enables.
- `src_n_to_w_last` in 1: final beat of the packet.
- `n_to_w_src_rdy` out 1: narrow beat accepted when val&rdy.
- `n_to_w_dst_val` out 1: wide line valid (registered).
- `n_to_w_dst_data` out `[OUT_DATA_ELS-1:0][IN_DATA_W]`: wide line data.
- `n_to_w_dst_keep` out `[OUT_DATA_ELS-1:0][IN_KEEP_W]`: wide line keep.
- `n_to_w_dst_last` out 1: line ends the packet.
- `dst_n_to_w_rdy` in 1: consumer ready.

## Operation
- Accumulator state:
  - `acc_data` and `acc_keep`, each `OUT_DATA_ELS` elements.
  - Element index `idx`, width `$clog2(OUT_DATA_ELS)`, counting down from `OUT_DATA_ELS-1`.
- Output register: `out_val`, `out_data`, `out_keep` and `out_last`. These drive the `n_to_w_dst_*` outputs directly.
- `n_to_w_src_rdy = rst_n & (~out_val | dst_n_to_w_rdy)`. It does not depend on `src_n_to_w_val` or `src_n_to_w_last`.
- On an accepted beat (`acc_fire`), the beat is written into element `idx`.
- Completing beat: an accepted beat with `idx==0` or `last==1`.
- Non-completing accepted beat:
  - Store data/keep at element `idx`.
  - `idx <= idx-1`.
- Completing accepted beat:
  - Load the output register with the accumulator merged with the current beat at `idx`.
  - Elements below `idx` are forced to data 0, keep 0.
  - `out_last <= src_n_to_w_last`; `out_val <= 1`.
  - Accumulator: `idx <= OUT_DATA_ELS-1`, `acc_keep <= 0`, `acc_data <= 0`.
- Output drain: on `out_val & dst_n_to_w_rdy` with no completing beat in the same cycle, `out_val <= 0`.
- Simultaneous drain and completing beat: the output register reloads with the new line and `out_val` stays 1.
- Keep values pass through unmodified, with no checking of contiguity. A beat with keep==0 is still stored and occupies its element.
- `last` on the first beat of a line produces a line with only element `OUT_DATA_ELS-1` populated.
- Output stability: `n_to_w_dst_*` are held stable while `out_val & ~dst_n_to_w_rdy`.

## Timing
- Reset (`rst_n` low, asynchronous) sets:
  - `n_to_w_dst_val=0`, `n_to_w_dst_data=0`, `n_to_w_dst_keep=0`, `n_to_w_dst_last=0`.
  - `idx=OUT_DATA_ELS-1`, `acc_data=0`, `acc_keep=0`.
- `n_to_w_src_rdy=0` while `rst_n` is low, and 1 in the first cycle after release.
- Reset mid-line discards any partial accumulator and any pending output line. There is no flush.
- Latency: a wide line is valid in the cycle after its completing beat is accepted.
- Throughput: one narrow beat per cycle sustained when `dst_n_to_w_rdy` is held 1. Full lines are emitted every `OUT_DATA_ELS` cycles with no bubbles.
- Backpressure:
  - `out_val=1 & dst_n_to_w_rdy=0` drives `n_to_w_src_rdy=0`, stalling even non-completing beats.
  - There is no combinational path from `src_n_to_w_*` to `n_to_w_dst_*`.
- Combinational path from `dst_n_to_w_rdy` to `n_to_w_src_rdy`. This path is the only one.
- Wrap-around: `idx` returns to `OUT_DATA_ELS-1` after every completing beat. It never underflows.

## Test plan
Configuration: `IN_DATA_W=64`, `OUT_DATA_ELS=4`.
- Reset check: hold `rst_n` low, then release it.
  - During reset: `dst_val=0`, `data=0`, `keep=0`, `last=0`, `src_rdy=0`.
  - In the cycle after release: `src_rdy=1`.
- Full line: feed beats A,B,C,D back-to-back, each with keep=0xFF and D carrying last.
  - Response: one line with `data={A,B,C,D}` (element 3 = A), `keep={FF,FF,FF,FF}`, `last=1`.
  - The line is valid the cycle after D is accepted.
- Short line: feed beats A, then B with keep=0x0F and last.
  - Response: `data={A,B,0,0}`, `keep={FF,0F,00,00}`, `last=1`.
- Streaming: 12 beats back-to-back with last on beat 12 and `dst_rdy=1`.
  - Response: 3 lines on cycles 5, 9 and 13 after the first beat, with `last` set only on the third line and `src_rdy` constantly 1.
- Backpressure: hold `dst_rdy=0` after the first line completes.
  - Response: `src_rdy=0` and the line is held stable.
  - Raising `dst_rdy` while the next completing beat is presented transfers the line and loads the new one in the same cycle, with `dst_val` staying 1.
- Reset mid-line: assert `rst_n` low after 2 beats, then send 4 new beats.
  - Response: a single line containing only the 4 new beats.
